// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response port: one outstanding request, variable
// grant and response latency.
interface if_fetch_stage_if #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic              req;
  logic [PC_W-1:0]   addr;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding fetches and
// buffers one instruction for the IF/ID register, with redirect/kill handling.
module if_fetch_stage #(
  parameter int unsigned       PC_W      = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [PC_W-1:0]   RESET_PC  = 32'h0000_0000,
  parameter logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  if_fetch_stage_if.master  im,
  input  logic              redirect_valid_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  input  logic              id_ready_i,
  output logic [PC_W-1:0]   if_pc_o,
  output logic [DATA_W-1:0] if_instr_o,
  output logic              if_valid_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   req_addr_q, req_addr_d;
  logic [PC_W-1:0]   if_pc_q, if_pc_d;
  logic [DATA_W-1:0] if_instr_q, if_instr_d;
  logic              if_valid_q, if_valid_d;
  logic              req_pending_q, req_pending_d;
  logic              kill_q, kill_d;

  logic              req_start;
  logic              req_active;
  logic              rsp_take;
  logic              rsp_load;
  logic              addr_hold;
  logic [PC_W-1:0]   redirect_tgt;

  assign redirect_tgt = {redirect_pc_i[PC_W-1:2], 2'b00};
  // A new fetch may only start if the buffer will have room for its data.
  assign req_start = (state_q == StReq) && !req_pending_q && (!if_valid_q || id_ready_i);
  assign rsp_take  = (state_q == StWait) && im.rvalid;
  assign rsp_load  = rsp_take && !kill_q && !redirect_valid_i;
  // req_addr belongs to the in-flight request; otherwise it shadows the PC.
  assign addr_hold = ((state_q == StReq) && req_active) || ((state_q == StWait) && !im.rvalid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StReq;
      StReq:   if (req_active && im.gnt) state_d = StWait;
      StWait:  if (im.rvalid) state_d = StReq;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_active = 1'b0;
    if (state_q == StReq) begin
      req_active = req_pending_q || req_start;
    end
  end

  assign im.req  = req_active;
  assign im.addr = req_addr_q;

  always_comb begin
    pc_d          = pc_q;
    kill_d        = kill_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    req_pending_d = (state_q == StReq) && req_active && !im.gnt;

    if (redirect_valid_i) begin
      pc_d = redirect_tgt;
    end else if (rsp_load) begin
      pc_d = req_addr_q + PC_W'(4);
    end
    req_addr_d = addr_hold ? req_addr_q : pc_d;

    if (rsp_take) begin
      kill_d = 1'b0;
    end
    if (redirect_valid_i && addr_hold) begin
      kill_d = 1'b1;
    end

    if (redirect_valid_i) begin
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
    end else if (rsp_load) begin
      if_valid_d = 1'b1;
      if_pc_d    = req_addr_q;
      if_instr_d = im.rdata;
    end else if (if_valid_q && id_ready_i) begin
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      req_addr_q    <= RESET_PC;
      req_pending_q <= 1'b0;
      kill_q        <= 1'b0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= '0;
      if_instr_q    <= NOP_INSTR;
    end else begin
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      req_pending_q <= req_pending_d;
      kill_q        <= kill_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
    end
  end

  assign if_pc_o    = if_pc_q;
  assign if_instr_o = if_instr_q;
  assign if_valid_o = if_valid_q;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and issues one-outstanding-request fetches to the instruction-memory port, which has variable grant/response latency.
- Buffers the returned instruction and presents pc/instr/valid to the IF/ID register under its write-enable backpressure.
- Handles branch/jump redirects from EX, including killing in-flight fetches.

Parameters:
PC_W, 32, width of PC and memory address
DATA_W, 32, instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven when no valid instruction is buffered

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
im_req  out  1  fetch request to instruction memory
im_addr  out  PC_W  fetch address; stable while im_req=1 and im_gnt=0
im_gnt  in  1  address accepted this cycle when im_req=1
im_rvalid  in  1  read data valid; exactly one per granted request, earliest the cycle after grant
im_rdata  in  DATA_W  read data
redirect_valid  in  1  taken branch/jump from EX, single-cycle pulse
redirect_pc  in  PC_W  redirect target; bits [1:0] forced to 0 internally
id_ready  in  1  IF/ID register write enable; when 1, IF/ID samples if_pc/if_instr this edge
if_pc  out  PC_W  PC of buffered instruction
if_instr  out  DATA_W  buffered instruction; NOP_INSTR when if_valid=0
if_valid  out  1  buffer holds a valid instruction

Behaviour:
- Reset, synchronous, dominates everything: state=IDLE, pc=RESET_PC, req_addr=RESET_PC, kill=0, buf_valid=0, if_pc=0, if_instr=NOP_INSTR, if_valid=0, im_req=0.
- An in-flight response arriving after reset is ignored; the memory side is reset by the same rst.
- All outputs are registered except im_req, which is decoded from state/flags.
- States:
  - IDLE: one cycle after reset release, no request, then go to REQ.
  - REQ: request phase.
    - Start a request when (!buf_valid || id_ready) || req_pending. On start, latch req_addr=pc and set req_pending.
    - im_req=1 while req_pending or starting; im_addr=req_addr. Once raised, im_req stays 1 until im_gnt; it never drops on backpressure.
    - On im_gnt: clear req_pending, go to WAIT.
  - WAIT: one request outstanding, im_req=0.
    - On im_rvalid with kill=1: discard data, clear kill, go to REQ.
    - On im_rvalid with kill=0: load buffer (if_pc=req_addr, if_instr=im_rdata, if_valid=1), set pc=req_addr+4 (mod 2^PC_W), go to REQ.
- Buffer consume: at an edge with if_valid=1 and id_ready=1, if_valid clears unless a new response loads the same edge. A load takes priority and overwrites. A load into a full, unconsumed buffer cannot occur because the request gate prevents it.
- Redirect (highest priority after reset), on the edge where redirect_valid=1:
  - pc=redirect_pc & ~3.
  - Buffer flushed: if_valid=0, if_instr=NOP_INSTR.
  - kill=1 if state=WAIT without im_rvalid this cycle, or state=REQ with a request pending or granted this cycle.
  - Redirect coincident with im_rvalid in WAIT: data discarded, kill stays 0, go to REQ.
  - Redirect in REQ with an ungranted request: the old request continues with stable address. On grant go to WAIT with kill=1; the next request uses the redirect target.
  - A second redirect while kill=1 only updates pc.
- Minimum fetch-to-fetch interval with zero-wait memory (gnt at request, rvalid next cycle): 2 cycles.

Test Plan:
- Reset/first fetch: rst high 2 cycles then low, gnt immediate, rvalid next cycle with 0x00500093 -> im_addr=0x0; then if_pc=0x0, if_instr=0x00500093, if_valid=1; next im_addr=0x4.
- Variable latency: gnt delayed 2 cycles, rvalid 3 cycles after gnt -> im_req/im_addr held constant until gnt; if_valid stays 0 and if_instr=0x00000013 meanwhile; sequence 0x0,0x4,0x8 in order.
- Backpressure: id_ready=0 for 5 cycles with buffer full -> no new im_req starts, if_pc/if_instr stable; id_ready=1 -> next request to pc+4 issues.
- Redirect in WAIT: request for 0x8 outstanding, redirect_pc=0x100 -> returned 0x8 data discarded, if_valid=0, next im_addr=0x100, buffer then holds pc 0x100.
- Redirect same cycle as rvalid, and redirect during ungranted request: redirect_pc=0x203 -> target becomes 0x200; no stale instruction ever reaches if_valid=1.
- Wrap and mid-op reset: fetch at 0xFFFFFFFC -> next im_addr=0x0; rst asserted in WAIT -> all outputs return to reset values the next cycle; first post-reset fetch is RESET_PC.
